uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

Parametrised UART command loader that turns a received byte stream into word writes on a generic memory write port, plus a display-mode register. It sits between `uart_rx`/`uart_tx` and the video RAM or mapper write port in the top level. It extends the top-level loader state machine with:
- configurable address, data and count widths;
- memory back-pressure;
- an inter-byte timeout;
- ACK/NAK responses;
- an optional packet checksum.

## Interface
Parameters:
- `ADDR_W`, 16, memory word-address width; `ADDR_BYTES = ceil(ADDR_W/8)` is derived.
- `DATA_BYTES`, 2, bytes per memory word; `mem_data` is `8*DATA_BYTES` wide.
- `CNT_BYTES`, 2, width in bytes of the packet count field.
- `TIMEOUT_CYC`, 2_700_000, idle cycles allowed between bytes of one packet.
- `MODE_NUM`, 7, number of valid mode codes.

Ports:
- `clk`  in  1  system clock (27 MHz domain, same as `uart_rx`/`uart_tx`).
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_data`  in  8  received byte.
- `rx_data_valid`  in  1  one-cycle strobe; there is no back-pressure.
- `tx_data`  out  8  response byte.
- `tx_data_valid`  out  1  response valid; held until accepted.
- `tx_data_ready`  in  1  `uart_tx` accepts the byte.
- `mem_we`  out  1  write request; held until `mem_ready`.
- `mem_ready`  in  1  memory accepts the write.
- `mem_addr`  out  `ADDR_W`  word address.
- `mem_data`  out  `8*DATA_BYTES`  write data.
- `mode`  out  `$clog2(MODE_NUM)`  current display mode.
- `mode_we`  out  1  one-cycle pulse when `mode` changes.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  2  last error: 0 none, 1 timeout, 2 overrun, 3 checksum/unknown. Cleared at the start of the next packet.

## Operation
Packet framing:
- The first byte is the command.
  - 0x01 FILL: ADDR (LE), CNT (LE), one data word (LE), [CSUM].
  - 0x02 WRITE: ADDR (LE), CNT (LE), CNT+1 data words (LE each), [CSUM].
  - 0x30+n with n<MODE_NUM sets `mode` = n.
  - Any other byte is an unknown command.
- CNT=N writes N+1 words.
- The address increments by 1 after each accepted write and wraps modulo 2^ADDR_W.

States:
- IDLE: waits for a command byte.
  - FILL or WRITE → HDR.
  - Mode command → MODE.
  - Unknown command → RESP with NAK, `err`=3.
- MODE: `mode` and `mode_we` update in the cycle after the command byte; then → RESP with ACK.
- HDR: collects `ADDR_BYTES + CNT_BYTES` bytes using a byte index counter; then → DATA.
- DATA: collects `DATA_BYTES` bytes into the word assembler; then → WR.
- WR: asserts `mem_we` until a cycle where `mem_ready`=1; then decrements the remaining count.
  - FILL: repeats WR with the same data until the count is exhausted.
  - WRITE: returns to DATA.
  - When the count is exhausted → CSUM if enabled, else RESP with ACK.
- RESP: drives `tx_data` (0x06 ACK / 0x15 NAK) with `tx_data_valid` until `tx_data_ready`; then → IDLE.

Rx bytes and errors:
- A one-entry skid buffer holds an rx byte that arrives while in WR or RESP.
- If a second byte arrives while the buffer is full: `err`=2, the packet is abandoned, NAK is sent, and the FSM → RESP.
- Bytes arriving during RESP after an abort are discarded.

Reset values:
- All outputs 0; `mode`=0; FSM in IDLE; skid buffer empty.
- Reset mid-packet discards the packet; a write in progress is dropped.

## Timing
- `mem_we` rises in the cycle after the last byte of a word is captured.
- `mem_addr` and `mem_data` are stable while `mem_we`=1.
- Write acceptance is the rising edge where `mem_we` and `mem_ready` are both 1. `mem_we` may stay high back-to-back for FILL: one word per cycle with `mem_ready` tied high.
- The response byte is valid 1 cycle after the final write is accepted, or after the CSUM byte is received.
- Timeout:
  - The counter runs only in HDR, DATA and CSUM, and is cleared on every accepted rx byte.
  - When it reaches `TIMEOUT_CYC`: `err`=1, NAK is sent, and writes already accepted stand.
- If an rx byte and the timeout expiry occur in the same cycle, the byte wins.

## Configuration
`LOADER_CHECKSUM_EN`:
- Defined: the FILL and WRITE formats end with one CSUM byte. Its value is chosen so that the XOR of every packet byte, command through CSUM, is 0x00. A mismatch sends NAK with `err`=3; writes already performed are not undone.
- Undefined: no CSUM byte is expected and CSUM logic is absent; all packets that complete without error return ACK.

## Structure
- `loader_pkg` holds:
  - command codes (0x01, 0x02, 0x30);
  - the ACK/NAK codes;
  - the state enum;
  - the `err` code constants.
- Sub-module `uart_loader_skid`: one-entry byte buffer with a full flag and an overrun flag.

## Test plan
- WRITE: 02 10 00 01 00 34 12 78 56 with `mem_ready`=1 → two writes, (0x0010,0x1234) then (0x0011,0x5678), then ACK 0x06.
- FILL: 01 FF FF 02 00 AA 55 → writes 0x55AA to addresses 0xFFFF, 0x0000, 0x0001 (wrap), then ACK.
- `mem_ready` held low for 20 cycles during a WRITE, with the next two bytes arriving while stalled → first byte is held in the skid buffer, second sets `err`=2 and NAK 0x15 is sent.
- Timeout: 02 00 00, then silence for `TIMEOUT_CYC` cycles → NAK, `err`=1, `busy`=0 afterwards.
- Mode and unknown commands:
  - byte 0x34 → `mode`=4 with a one-cycle `mode_we`, then ACK;
  - byte 0x37 (with `MODE_NUM`=7) → NAK, `err`=3, `mode` unchanged.
- With `LOADER_CHECKSUM_EN` defined, a corrupted CSUM byte → writes occur, then NAK with `err`=3.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared constants and state encoding for the UART memory loader.
// Holds command/response byte codes, the err codes and the FSM state enum.
package loader_pkg;

  // Command bytes (first byte of a packet)
  localparam logic [7:0] CMD_FILL  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_MODE  = 8'h30;

  // Response bytes
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // err output codes
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODE,
    ST_HDR,
    ST_DATA,
    ST_WR,
    ST_CSUM,
    ST_RESP
  } state_e;

endpackage

// File: rtl/uart_loader_skid.sv
// uart_loader_skid: one-entry byte buffer for rx bytes that arrive while the
// loader cannot consume them.
// Ports: clk, rst (async, active-high); push/pop/flush controls; din byte in;
// dout held byte; full flag; overrun_c flags a push into a full, unpopped entry.
module uart_loader_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       overrun_c
);

  // A push while full is only an overrun if the held byte is not leaving.
  assign overrun_c = push && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push && (!full || pop)) begin
      full <= 1'b1;
      dout <= din;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: turns a UART byte stream into memory word writes and a
// display-mode register, answering each packet with ACK (0x06) or NAK (0x15).
// Ports: clk, rst (async, active-high); rx_data/rx_data_valid byte strobe in;
// tx_data/tx_data_valid/tx_data_ready response handshake; mem_we/mem_ready/
// mem_addr/mem_data write port; mode/mode_we display mode; busy; err code.
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte on FILL and WRITE packets.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_BYTES  = 2,
  parameter int unsigned CNT_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYC = 2_700_000,
  parameter int unsigned MODE_NUM    = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_data_valid,
  output logic [7:0]                   tx_data,
  output logic                         tx_data_valid,
  input  logic                         tx_data_ready,
  output logic                         mem_we,
  input  logic                         mem_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [8*DATA_BYTES-1:0]      mem_data,
  output logic [$clog2(MODE_NUM)-1:0]  mode,
  output logic                         mode_we,
  output logic                         busy,
  output logic [1:0]                   err
);

  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned HDR_BYTES  = ADDR_BYTES + CNT_BYTES;
  localparam int unsigned HDR_W      = 8 * HDR_BYTES;
  localparam int unsigned DATA_W     = 8 * DATA_BYTES;
  localparam int unsigned CNT_W      = 8 * CNT_BYTES;
  localparam int unsigned MODE_W     = $clog2(MODE_NUM);
  localparam int unsigned IDX_W      = $clog2(HDR_BYTES + DATA_BYTES);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  MODE_END   = 8'(32'(CMD_MODE) + MODE_NUM);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d, hdr_sh;
  logic [DATA_W-1:0]   word_d, word_sh;
  logic [ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fill_q, fill_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [1:0]          err_d;
  logic [MODE_W-1:0]   mode_d;
  logic                mode_we_d;
  logic [7:0]          tx_d;
  logic                drop_q, drop_d;

  logic       consume_c, byte_v_c, run_tmo_c, flush_c;
  logic [7:0] byte_c, skid_dout;
  logic       skid_full, skid_push_c, skid_pop_c, skid_ovr_c;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  // States that take a byte as soon as one is available; elsewhere rx bytes park in the skid buffer.
  assign consume_c   = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign run_tmo_c   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  // The buffered byte is older than a live rx byte, so it goes first.
  assign byte_v_c    = skid_full || rx_data_valid;
  assign byte_c      = skid_full ? skid_dout : rx_data;
  assign skid_pop_c  = consume_c && skid_full;
  assign skid_push_c = rx_data_valid && !(consume_c && !skid_full) &&
                       !((state_q == ST_RESP) && drop_q);

  uart_loader_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push_c),
    .pop       (skid_pop_c),
    .flush     (flush_c),
    .din       (rx_data),
    .dout      (skid_dout),
    .full      (skid_full),
    .overrun_c (skid_ovr_c)
  );

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hdr_d     = hdr_q;
    word_d    = mem_data;
    addr_d    = mem_addr;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    tmo_d     = '0;
    err_d     = err;
    mode_d    = mode;
    mode_we_d = 1'b0;
    tx_d      = tx_data;
    drop_d    = drop_q;
    flush_c   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    // Little-endian assembly: each new byte enters at the top and shifts down.
    hdr_sh    = HDR_W'({byte_c, hdr_q} >> 8);
    word_sh   = DATA_W'({byte_c, mem_data} >> 8);

    case (state_q)
      ST_IDLE: begin
        if (byte_v_c) begin
          err_d = ERR_NONE;
          idx_d = '0;
          if ((byte_c == CMD_FILL) || (byte_c == CMD_WRITE)) begin
            fill_d  = (byte_c == CMD_FILL);
            state_d = ST_HDR;
          end else if ((byte_c >= CMD_MODE) && (byte_c < MODE_END)) begin
            mode_d    = MODE_W'(byte_c - CMD_MODE);
            mode_we_d = 1'b1;
            state_d   = ST_MODE;
          end else begin
            err_d   = ERR_CSUM;
            tx_d    = RSP_NAK;
            state_d = ST_RESP;
          end
        end
      end
      ST_MODE: begin
        tx_d    = RSP_ACK;
        state_d = ST_RESP;
      end
      ST_HDR: begin
        if (byte_v_c) begin
          hdr_d = hdr_sh;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(HDR_BYTES - 1)) begin
            addr_d  = hdr_sh[ADDR_W-1:0];
            cnt_d   = hdr_sh[HDR_W-1 -: CNT_W];
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_v_c) begin
          word_d = word_sh;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BYTES - 1)) begin
            idx_d   = '0;
            state_d = ST_WR;
          end
        end
      end
      ST_WR: begin
        // mem_we is high throughout this state, so mem_ready alone marks acceptance.
        if (mem_ready) begin
          addr_d = mem_addr + ADDR_W'(1);
          if (cnt_q == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            tx_d    = RSP_ACK;
            state_d = ST_RESP;
`endif
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = fill_q ? ST_WR : ST_DATA;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_v_c) begin
          if ((csum_q ^ byte_c) == 8'h00) begin
            tx_d = RSP_ACK;
          end else begin
            tx_d  = RSP_NAK;
            err_d = ERR_CSUM;
          end
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (tx_data_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every consumed packet byte before the checksum byte.
    if (byte_v_c && (state_q == ST_IDLE)) begin
      csum_d = byte_c;
    end else if (byte_v_c && ((state_q == ST_HDR) || (state_q == ST_DATA))) begin
      csum_d = csum_q ^ byte_c;
    end
`endif

    // Inter-byte timeout; a byte in the expiry cycle wins.
    if (run_tmo_c && !byte_v_c) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        err_d   = ERR_TIMEOUT;
        tx_d    = RSP_NAK;
        state_d = ST_RESP;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    // Second byte while the skid entry is still held: abandon the packet.
    if (skid_ovr_c) begin
      flush_c = 1'b1;
      err_d   = ERR_OVERRUN;
      drop_d  = 1'b1;
      if (state_q != ST_RESP) begin
        tx_d    = RSP_NAK;
        state_d = ST_RESP;
      end
    end

    // After a NAK, rx bytes during the response are treated as stale and dropped.
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      drop_d = (tx_d == RSP_NAK);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      hdr_q         <= '0;
      mem_data      <= '0;
      mem_addr      <= '0;
      cnt_q         <= '0;
      fill_q        <= 1'b0;
      tmo_q         <= '0;
      err           <= ERR_NONE;
      mode          <= '0;
      mode_we       <= 1'b0;
      tx_data       <= '0;
      drop_q        <= 1'b0;
      mem_we        <= 1'b0;
      tx_data_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hdr_q         <= hdr_d;
      mem_data      <= word_d;
      mem_addr      <= addr_d;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      tmo_q         <= tmo_d;
      err           <= err_d;
      mode          <= mode_d;
      mode_we       <= mode_we_d;
      tx_data       <= tx_d;
      drop_q        <= drop_d;
      mem_we        <= (state_d == ST_WR);
      tx_data_valid <= (state_d == ST_RESP);
      busy          <= (state_d != ST_IDLE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: self-checking bench for uart_mem_loader. Builds packets
// from field values, predicts writes/response/err/mode from the packet format,
// and compares against what the DUT produces on its ports.
module tb_uart_mem_loader;

  localparam int unsigned TC = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready = 1'b0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [2:0]  mode;
  logic        mode_we;
  logic        busy;
  logic [1:0]  err;

  always #5 clk = ~clk;

  uart_mem_loader #(
    .ADDR_W(16), .DATA_BYTES(2), .CNT_BYTES(2), .TIMEOUT_CYC(TC), .MODE_NUM(7)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mode(mode), .mode_we(mode_we), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rsp_cyc = 0;
  int t_last = 0;
  int mode_we_cnt = 0;
  int rdy_mode = 0;  // 0: random ready with bounded stalls, 1: mem stalled, 2: all ready
  int mstall = 0;
  int tstall = 0;

  logic [31:0] wr_q[$];
  logic [7:0]  rsp_q[$];
  logic [7:0]  pkt[$];
  logic [31:0] exp_wr[$];
  logic [15:0] wq[$];
  logic [2:0]  mode_model = 3'd0;
`ifdef LOADER_CHECKSUM_EN
  bit corrupt = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready drivers: random, but never more than 3 consecutive low cycles.
  always @(posedge clk) begin : rdy_drv
    logic mr, tr;
    #1;
    mr = ($urandom_range(0, 2) != 0) || (mstall >= 3);
    tr = ($urandom_range(0, 1) != 0) || (tstall >= 3);
    if (rdy_mode == 1) mr = 1'b0;
    if (rdy_mode == 2) begin
      mr = 1'b1;
      tr = 1'b1;
    end
    mstall = mr ? 0 : mstall + 1;
    tstall = tr ? 0 : tstall + 1;
    mem_ready     = mr;
    tx_data_ready = tr;
  end

  // Port monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) wr_q.push_back({mem_addr, mem_data});
    if (!rst && tx_data_valid && tx_data_ready) begin
      rsp_q.push_back(tx_data);
      rsp_cyc = cyc;
    end
    if (!rst && mode_we) mode_we_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Packet image and expected writes from field values (uses wq as data words).
  task automatic make_pkt(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] cnt);
    int nw;
    pkt.delete();
    exp_wr.delete();
    pkt.push_back(cmd);
    pkt.push_back(addr[7:0]);
    pkt.push_back(addr[15:8]);
    pkt.push_back(cnt[7:0]);
    pkt.push_back(cnt[15:8]);
    nw = (cmd == 8'h01) ? 1 : int'(cnt) + 1;
    for (int i = 0; i < nw; i++) begin
      pkt.push_back(wq[i][7:0]);
      pkt.push_back(wq[i][15:8]);
    end
    for (int i = 0; i <= int'(cnt); i++) begin
      exp_wr.push_back({16'(int'(addr) + i), (cmd == 8'h01) ? wq[0] : wq[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (pkt[i]) x = x ^ pkt[i];
      pkt.push_back(corrupt ? ~x : x);
    end
`endif
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] exp_rsp, input logic [1:0] exp_err,
                         input int gap);
    int w;
    logic [7:0] r;
    wr_q.delete();
    rsp_q.delete();
    foreach (pkt[i]) send_byte(pkt[i], gap);
    t_last = cyc;
    w = 0;
    while (rsp_q.size() == 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check({tag, "/rsp_count"}, 32'(rsp_q.size()), 32'd1);
    r = (rsp_q.size() != 0) ? rsp_q[0] : 8'hEE;
    check({tag, "/rsp"}, 32'(r), 32'(exp_rsp));
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/busy"}, 32'(busy), 32'd0);
    check({tag, "/wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      check($sformatf("%s/wr%0d", tag, i), wr_q[i], exp_wr[i]);
    end
  endtask

  initial begin
    int mwe0;
    // Reset state
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst/tx_valid", 32'(tx_data_valid), 32'd0);
    check("rst/tx_data", 32'(tx_data), 32'd0);
    check("rst/mem_we", 32'(mem_we), 32'd0);
    check("rst/mem_addr", 32'(mem_addr), 32'd0);
    check("rst/mode", 32'(mode), 32'd0);
    check("rst/mode_we", 32'(mode_we), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/err", 32'(err), 32'd0);

    // WRITE two words with memory always ready
    rdy_mode = 2;
    wq = '{16'h1234, 16'h5678};
    make_pkt(8'h02, 16'h0010, 16'h0001);
    run_pkt("write", 8'h06, 2'd0, 5);

    // FILL wrapping through the top of the address space
    wq = '{16'h55AA};
    make_pkt(8'h01, 16'hFFFF, 16'h0002);
    run_pkt("fill_wrap", 8'h06, 2'd0, 5);

    // Memory stalled: one byte parks in the skid buffer, the next one overruns
    rdy_mode = 1;
    wq = '{16'h1234, 16'h5678};
    make_pkt(8'h02, 16'h0010, 16'h0001);
`ifdef LOADER_CHECKSUM_EN
    void'(pkt.pop_back());
`endif
    exp_wr.delete();
    run_pkt("overrun", 8'h15, 2'd2, 1);
    rdy_mode = 0;

    // Inter-byte timeout
    rdy_mode = 2;
    pkt = '{8'h02, 8'h00, 8'h00};
    exp_wr.delete();
    run_pkt("timeout", 8'h15, 2'd1, 0);
    check("timeout/latency", 32'(rsp_cyc - t_last), 32'(TC));

    // Mode command and out-of-range mode code
    mwe0 = mode_we_cnt;
    pkt = '{8'h34};
    exp_wr.delete();
    run_pkt("mode4", 8'h06, 2'd0, 2);
    mode_model = 3'd4;
    check("mode4/mode", 32'(mode), 32'(mode_model));
    check("mode4/mode_we_pulses", 32'(mode_we_cnt - mwe0), 32'd1);
    mwe0 = mode_we_cnt;
    pkt = '{8'h37};
    run_pkt("mode7", 8'h15, 2'd3, 2);
    check("mode7/mode", 32'(mode), 32'(mode_model));
    check("mode7/mode_we_pulses", 32'(mode_we_cnt - mwe0), 32'd0);
    rdy_mode = 0;

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: writes stand, response is NAK
    corrupt = 1'b1;
    wq = '{16'hBEEF, 16'hCAFE};
    make_pkt(8'h02, 16'h0100, 16'h0001);
    corrupt = 1'b0;
    run_pkt("bad_csum", 8'h15, 2'd3, 5);
`endif

    // Reset in the middle of a packet
    send_byte(8'h02, 2);
    send_byte(8'h10, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/mem_we", 32'(mem_we), 32'd0);
    check("midrst/mode", 32'(mode), 32'd0);
    mode_model = 3'd0;
    @(posedge clk); #1 rst = 1'b0;
    pkt = '{8'h32};
    exp_wr.delete();
    run_pkt("midrst_after", 8'h06, 2'd0, 2);
    mode_model = 3'd2;
    check("midrst_after/mode", 32'(mode), 32'(mode_model));

    // Random packets under random back-pressure
    for (int k = 0; k < 30; k++) begin
      int kind;
      int gap;
      string tag;
      kind = $urandom_range(0, 3);
      gap  = $urandom_range(5, 9);
      tag  = $sformatf("rnd%0d", k);
      if (kind <= 1) begin
        logic [15:0] a;
        logic [15:0] c;
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                        : 16'($urandom_range(0, 16'hFFFF));
        c = 16'($urandom_range(0, 3));
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(16'($urandom_range(0, 16'hFFFF)));
        make_pkt((kind == 0) ? 8'h01 : 8'h02, a, c);
        run_pkt(tag, 8'h06, 2'd0, gap);
      end else if (kind == 2) begin
        int n;
        n = $urandom_range(0, 6);
        mwe0 = mode_we_cnt;
        pkt = '{8'(8'h30 + n)};
        exp_wr.delete();
        run_pkt(tag, 8'h06, 2'd0, gap);
        mode_model = 3'(n);
        check({tag, "/mode_we_pulses"}, 32'(mode_we_cnt - mwe0), 32'd1);
      end else begin
        int b;
        do b = $urandom_range(0, 255);
        while (b == 1 || b == 2 || (b >= 8'h30 && b < 8'h37));
        pkt = '{8'(b)};
        exp_wr.delete();
        run_pkt(tag, 8'h15, 2'd3, gap);
      end
      check({tag, "/mode"}, 32'(mode), 32'(mode_model));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
